// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster timing definitions.
//   - coord_t: 10-bit pixel coordinate (column or row), enough for totals up to 1024.
//   - DEF_*: default 640x480@60 Hz timing in pixels (horizontal) and lines (vertical).
//   - H_TOTAL/V_TOTAL and the sync window bounds derived from those defaults.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned HS_BEGIN = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned HS_END   = HS_BEGIN + DEF_H_SYNC - 1;
    localparam int unsigned VS_BEGIN = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned VS_END   = VS_BEGIN + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap-at-limit coordinate counter for one raster axis.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   enable     : advance the count on this edge
//   count      : registered current coordinate, 0..LIMIT-1
//   count_next : value count takes on the next edge (ignores reset)
//   wrap       : enable is high and count is at LIMIT-1
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned LIMIT = H_TOTAL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] count,
    output logic [9:0] count_next,
    output logic       wrap
);

    localparam coord_t LAST = coord_t'(LIMIT - 1);

    always_comb begin
        wrap = enable && (count == LAST);
        if (wrap) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count + 10'd1;
        end else begin
            count_next = count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 Hz by default).
//   vga_clk      : pixel clock, all logic on its rising edge
//   reset        : synchronous active-high reset
//   DrawX/DrawY  : current pixel column/row
//   blank        : 1 while the pixel is in the visible region
//   hs/vs        : active-low horizontal/vertical sync
//   line_start   : pulse at DrawX==0
//   frame_start  : pulse at (0,0)
//   vblank_start : pulse at (0,V_VISIBLE), game-logic update strobe
//   frame_count  : frames completed since reset, 8-bit wrapping
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_LEN = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    coord_t hc;
    coord_t vc;
    coord_t hc_next;
    coord_t vc_next;
    logic   h_wrap;
    logic   v_wrap;

    vga_axis_counter #(
        .LIMIT(H_LEN)
    ) u_h_counter (
        .clk        (vga_clk),
        .reset      (reset),
        .enable     (1'b1),
        .count      (hc),
        .count_next (hc_next),
        .wrap       (h_wrap)
    );

    // The vertical counter only advances on the horizontal wrap, so its wrap
    // marks the (H_LEN-1, V_LEN-1) -> (0,0) transition.
    vga_axis_counter #(
        .LIMIT(V_LEN)
    ) u_v_counter (
        .clk        (vga_clk),
        .reset      (reset),
        .enable     (h_wrap),
        .count      (vc),
        .count_next (vc_next),
        .wrap       (v_wrap)
    );

    assign DrawX = hc;
    assign DrawY = vc;

    // Decoded from the next-state coordinates and registered, so each output
    // lines up with the DrawX/DrawY value loaded on the same edge.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank        <= 1'b1;
            hs           <= 1'b1;
            vs           <= 1'b1;
            line_start   <= 1'b1;
            frame_start  <= 1'b1;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            blank        <= (hc_next < H_VIS) && (vc_next < V_VIS);
            hs           <= !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
            vs           <= !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
            line_start   <= (hc_next == '0);
            frame_start  <= (hc_next == '0) && (vc_next == '0);
            vblank_start <= (hc_next == '0) && (vc_next == V_VIS);
            if (v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// A reduced-timing instance (16x12 total) is exercised through whole frames and
// frame_count wrap; a default-timing instance runs alongside for line-level
// behaviour. Both are tracked cycle by cycle through a scoreboard queue.
module tb_vga_timing_gen;

    localparam int S_HV = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VV = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;  // 16
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;  // 12

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       vb;
        logic [7:0] fc;
    } vec_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit b;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        bit vb;
        int fc;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs, s_vb;
    logic       d_blank, d_hs, d_vs, d_ls, d_fs, d_vb;
    logic [7:0] s_fc, d_fc;

    int errors = 0;
    int checks = 0;

    int sx = 0, sy = 0, sfc = 0;
    int dx = 0, dy = 0, dfc = 0;
    vec_t q_s[$];
    vec_t q_d[$];
    row_t tbl[14];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_small (
        .vga_clk      (clk),
        .reset        (reset),
        .DrawX        (s_x),
        .DrawY        (s_y),
        .blank        (s_blank),
        .hs           (s_hs),
        .vs           (s_vs),
        .line_start   (s_ls),
        .frame_start  (s_fs),
        .vblank_start (s_vb),
        .frame_count  (s_fc)
    );

    vga_timing_gen dut_def (
        .vga_clk      (clk),
        .reset        (reset),
        .DrawX        (d_x),
        .DrawY        (d_y),
        .blank        (d_blank),
        .hs           (d_hs),
        .vs           (d_vs),
        .line_start   (d_ls),
        .frame_start  (d_fs),
        .vblank_start (d_vb),
        .frame_count  (d_fc)
    );

    function automatic vec_t expect_at(input int x, input int y, input int fc,
                                       input int hv, input int hf, input int hsy,
                                       input int vv, input int vf, input int vsy);
        vec_t e;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.blank = (x < hv) && (y < vv);
        e.hs    = !((x >= hv + hf) && (x < hv + hf + hsy));
        e.vs    = !((y >= vv + vf) && (y < vv + vf + vsy));
        e.ls    = (x == 0);
        e.fs    = (x == 0) && (y == 0);
        e.vb    = (x == 0) && (y == vv);
        e.fc    = 8'(fc);
        return e;
    endfunction

    task automatic model_adv(input bit rst, inout int x, inout int y, inout int fc,
                             input int ht, input int vt);
        if (rst) begin
            x = 0; y = 0; fc = 0;
        end else if (x == ht - 1) begin
            x = 0;
            if (y == vt - 1) begin
                y = 0;
                fc = (fc + 1) % 256;
            end else begin
                y = y + 1;
            end
        end else begin
            x = x + 1;
        end
    endtask

    function automatic vec_t act_small();
        return {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc};
    endfunction

    function automatic vec_t act_def();
        return {d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs, d_vb, d_fc};
    endfunction

    task automatic report(input string name, input vec_t a, input vec_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d",
                     name, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, a.vb, a.fc,
                     e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.vb, e.fc);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, a, e);
        end
    endtask

    // Drive one cycle: model predicts the post-edge state and queues it; the
    // DUT outputs are compared against the queue head on the falling edge.
    task automatic step(input bit rst);
        reset = rst;
        @(posedge clk);
        model_adv(rst, sx, sy, sfc, S_HT, S_VT);
        model_adv(rst, dx, dy, dfc, 800, 525);
        q_s.push_back(expect_at(sx, sy, sfc, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS));
        q_d.push_back(expect_at(dx, dy, dfc, 640, 16, 96, 480, 10, 2));
        @(negedge clk);
        if (q_s.size() == 0 || q_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got %0d entries, want >=1", q_s.size());
        end else begin
            report("sb_small", act_small(), q_s.pop_front());
            report("sb_default", act_def(), q_d.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    // From a frame_start cycle, run to the next frame_start and check the
    // period and the number of visible cycles in between.
    task automatic measure_frame(input string name);
        int cyc;
        int bl;
        bit found;
        cyc = 0;
        bl = int'(s_blank);
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            step(1'b0);
            cyc++;
            if (s_fs) found = 1;
            else bl += int'(s_blank);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no frame_start in 1000 cycles, want one at %0d", name, S_HT * S_VT);
        end else begin
            check_int({name, "_period"}, cyc, S_HT * S_VT);
            check_int({name, "_blank_cycles"}, bl, S_HV * S_VV);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        vec_t e;

        // {n cycles to advance, x, y, blank, hs, vs, line_start, frame_start, vblank_start, frame_count}
        tbl[0]  = '{0,   0,  0, 1, 1, 1, 1, 1, 0, 0};
        tbl[1]  = '{1,   1,  0, 1, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{7,   8,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{2,  10,  0, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{2,  12,  0, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{1,  13,  0, 0, 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{3,   0,  1, 1, 1, 1, 1, 0, 0, 0};
        tbl[7]  = '{80,  0,  6, 0, 1, 1, 1, 0, 1, 0};
        tbl[8]  = '{1,   1,  6, 0, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{31,  0,  8, 0, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{31, 15,  9, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{1,   0, 10, 0, 1, 1, 1, 0, 0, 0};
        tbl[12] = '{31, 15, 11, 0, 1, 1, 0, 0, 0, 0};
        tbl[13] = '{1,   0,  0, 1, 1, 1, 1, 1, 0, 1};

        // Reset, run to an arbitrary point, then reset again for 3 cycles.
        for (int k = 0; k < 3; k++) step(1'b1);
        run(37);
        for (int k = 0; k < 3; k++) step(1'b1);

        for (int i = 0; i < 14; i++) begin
            run(tbl[i].n);
            e = {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].b, tbl[i].hs, tbl[i].vs,
                 tbl[i].ls, tbl[i].fs, tbl[i].vb, 8'(tbl[i].fc)};
            report($sformatf("row%0d", i), act_small(), e);
        end

        // Full frame from (0,0): period and visible-cycle count; frame_count -> 2.
        measure_frame("frame");
        check_int("fc_after_frame", int'(s_fc), 2);

        // frame_count wrap 255 -> 0 coincident with frame_start.
        run(S_HT * S_VT * 253);
        check_int("fc_at_255", int'(s_fc), 255);
        check_int("fs_at_255", int'(s_fs), 1);
        run(S_HT * S_VT - 1);
        check_int("fc_before_wrap", int'(s_fc), 255);
        check_int("fs_before_wrap", int'(s_fs), 0);
        run(1);
        check_int("fc_wrapped", int'(s_fc), 0);
        check_int("fs_at_wrap", int'(s_fs), 1);

        // Mid-frame reset at (5,3) with frame_count=5.
        run(S_HT * S_VT * 5 + 3 * S_HT + 5);
        check_int("fc_before_reset", int'(s_fc), 5);
        check_int("x_before_reset", int'(s_x), 5);
        check_int("y_before_reset", int'(s_y), 3);
        step(1'b1);
        report("midframe_reset", act_small(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        report("midframe_reset_def", act_def(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        measure_frame("after_reset");
        check_int("fc_after_reset_frame", int'(s_fc), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
